yin_threshold_picker: RTL

- Consumer of the cumulative-mean-normalised difference vector produced by the modified-difference stage. It sits directly after that stage in the YIN pitch path.
- Scans d'(tau) one lag per clock, using the YIN absolute-threshold rule. It finds the first lag below threshold, then follows the descent to that dip's local minimum.
- If no lag crosses the threshold, it reports the global minimum as unvoiced.
- Its output (period in lags plus voiced flag) feeds the pitch/frequency conversion stage.

---
 rtl/yin_pkg.sv | 18 +
 rtl/yin_word_mux.sv | 19 +
 rtl/yin_threshold_picker.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/yin_pkg.sv
// Shared types and defaults for the YIN pitch path (threshold picker and its neighbours).
package yin_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DESCEND,
    DONE
  } yin_state_t;

  localparam int unsigned DEFAULT_DATA_WIDTH = 64;
  localparam int unsigned DEFAULT_MAX_TAU    = 40;
  localparam int unsigned DEFAULT_TAU_BITS   = 6;

  // 0.1 in the Q32.32 d' scaling used by the normaliser.
  localparam logic [DEFAULT_DATA_WIDTH-1:0] THRESH_DEFAULT = 64'd429496730;

endpackage

// File: rtl/yin_word_mux.sv
// Combinational N:1 word select from a flat packed bus; word k lives at bits [k*W +: W].
module yin_word_mux #(
  parameter int unsigned W        = 64,
  parameter int unsigned N        = 40,
  parameter int unsigned SEL_BITS = 6
) (
  input  logic [N*W-1:0]    words_i,
  input  logic [SEL_BITS-1:0] sel_i,
  output logic [W-1:0]      word_o
);

  always_comb begin
    word_o = '0;
    if (32'(sel_i) < N) begin
      word_o = words_i[32'(sel_i)*W +: W];
    end
  end

endmodule

// File: rtl/yin_threshold_picker.sv
// YIN absolute-threshold lag picker: first dip below threshold followed to its local
// minimum, or the global minimum reported as unvoiced when nothing crosses.
module yin_threshold_picker
  import yin_pkg::*;
#(
  parameter int unsigned INTERMEDIATE_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned MAX_TAU                 = DEFAULT_MAX_TAU,
  parameter int unsigned MIN_TAU                 = 2,
  parameter int unsigned TAU_BITS                = DEFAULT_TAU_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  results_ready,
  input  logic [MAX_TAU*INTERMEDIATE_DATA_WIDTH-1:0] results,
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0]    threshold,
  output logic                                  done,
  output logic [TAU_BITS-1:0]                   tau_out,
  output logic [INTERMEDIATE_DATA_WIDTH-1:0]    min_value,
  output logic                                  voiced
);

  localparam int unsigned W = INTERMEDIATE_DATA_WIDTH;
  localparam logic [TAU_BITS-1:0] FIRST_TAU = TAU_BITS'(MIN_TAU);
  localparam logic [TAU_BITS-1:0] LAST_TAU  = TAU_BITS'(MAX_TAU - 1);

  yin_state_t          state_q, state_d;
  logic                ready_q;
  logic                done_q, done_d;
  logic                voiced_q, voiced_d;
  logic [TAU_BITS-1:0] tau_q, tau_d;
  logic [TAU_BITS-1:0] idx_q, idx_d;
  logic [TAU_BITS-1:0] cand_q, cand_d;
  logic [TAU_BITS-1:0] gmin_idx_q, gmin_idx_d;
  logic [W-1:0]        gmin_val_q, gmin_val_d;
  logic [W-1:0]        thr_q, thr_d;
  logic [W-1:0]        min_q, min_d;

  logic [W-1:0]        idx_word;
  logic [W-1:0]        cand_word;
  logic                gmin_hit;
  logic                is_last;

  yin_word_mux #(
    .W        (W),
    .N        (MAX_TAU),
    .SEL_BITS (TAU_BITS)
  ) u_idx_mux (
    .words_i (results),
    .sel_i   (idx_q),
    .word_o  (idx_word)
  );

  yin_word_mux #(
    .W        (W),
    .N        (MAX_TAU),
    .SEL_BITS (TAU_BITS)
  ) u_cand_mux (
    .words_i (results),
    .sel_i   (cand_q),
    .word_o  (cand_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      voiced_q   <= 1'b0;
      tau_q      <= '0;
      idx_q      <= '0;
      cand_q     <= '0;
      gmin_idx_q <= '0;
      gmin_val_q <= '1;
      thr_q      <= '0;
      min_q      <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= results_ready;
      done_q     <= done_d;
      voiced_q   <= voiced_d;
      tau_q      <= tau_d;
      idx_q      <= idx_d;
      cand_q     <= cand_d;
      gmin_idx_q <= gmin_idx_d;
      gmin_val_q <= gmin_val_d;
      thr_q      <= thr_d;
      min_q      <= min_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    voiced_d   = voiced_q;
    tau_d      = tau_q;
    idx_d      = idx_q;
    cand_d     = cand_q;
    gmin_idx_d = gmin_idx_q;
    gmin_val_d = gmin_val_q;
    thr_d      = thr_q;
    min_d      = min_q;
    gmin_hit   = idx_word < gmin_val_q;
    is_last    = idx_q == LAST_TAU;

    unique case (state_q)
      IDLE: begin
        if (results_ready && !ready_q) begin
          state_d    = SCAN;
          idx_d      = FIRST_TAU;
          gmin_idx_d = FIRST_TAU;
          gmin_val_d = '1;
          thr_d      = threshold;
        end
      end

      SCAN: begin
        if (!results_ready) begin
          state_d = IDLE;
        end else begin
          if (gmin_hit) begin
            gmin_val_d = idx_word;
            gmin_idx_d = idx_q;
          end
          if (idx_word < thr_q) begin
            cand_d = idx_q;
            if (is_last) begin
              state_d  = DONE;
              tau_d    = idx_q;
              min_d    = idx_word;
              voiced_d = 1'b1;
            end else begin
              idx_d   = idx_q + TAU_BITS'(1);
              state_d = DESCEND;
            end
          end else if (is_last) begin
            // Fallback result must include the lag compared in this same cycle.
            state_d  = DONE;
            tau_d    = gmin_hit ? idx_q : gmin_idx_q;
            min_d    = gmin_hit ? idx_word : gmin_val_q;
            voiced_d = 1'b0;
          end else begin
            idx_d = idx_q + TAU_BITS'(1);
          end
        end
      end

      DESCEND: begin
        if (!results_ready) begin
          state_d = IDLE;
        end else if (idx_word < cand_word) begin
          cand_d = idx_q;
          if (is_last) begin
            state_d  = DONE;
            tau_d    = idx_q;
            min_d    = idx_word;
            voiced_d = 1'b1;
          end else begin
            idx_d = idx_q + TAU_BITS'(1);
          end
        end else begin
          state_d  = DONE;
          tau_d    = cand_q;
          min_d    = cand_word;
          voiced_d = 1'b1;
        end
      end

      DONE: begin
        if (!results_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    done_d = state_d == DONE;
  end

  assign done      = done_q;
  assign tau_out   = tau_q;
  assign min_value = min_q;
  assign voiced    = voiced_q;

endmodule
